// File: rtl/fifo_width_down_drain_pkg.sv
// Shared helpers for the width-down drain: size math, ratio legality, beat slicing.
// Functions work on a fixed MAX_W container so any legal parameterisation can use them.
package fifo_width_down_drain_pkg;

    localparam int unsigned MAX_W   = 256;
    localparam int unsigned WORDS_W = 16;

    typedef enum logic {
        EMPTY   = 1'b0,
        SENDING = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_ratio(input int unsigned in_w, input int unsigned out_w);
        return (out_w == 0) ? 0 : in_w / out_w;
    endfunction

    function automatic bit ratio_ok(input int unsigned in_w, input int unsigned out_w);
        return (out_w != 0) && (in_w <= MAX_W) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

    // Slot 0 is the least-significant slice; MSB-first walks the slots downward.
    function automatic logic [MAX_W-1:0] beat_select(
        input logic [MAX_W-1:0] word,
        input int unsigned      idx,
        input bit               msb_first,
        input int unsigned      out_w,
        input int unsigned      ratio
    );
        int unsigned      slot;
        logic [MAX_W-1:0] mask;
        slot = msb_first ? (ratio - 1 - idx) : idx;
        mask = '1;
        mask = mask >> (MAX_W - out_w);
        return (word >> (slot * out_w)) & mask;
    endfunction

endpackage

// File: rtl/fifo_width_down_drain.sv
// Dequeues wide words from an upstream FIFO and enqueues them downstream as RATIO narrow beats,
// overlapping the next dequeue with the last beat so consecutive words stream without a bubble.
module fifo_width_down_drain
    import fifo_width_down_drain_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_WIDTH-1:0]  src_first,
    input  logic                 src_first__RDY,
    input  logic                 src_deq__RDY,
    output logic                 src_deq__ENA,
    input  logic                 dst_enq__RDY,
    output logic                 dst_enq__ENA,
    output logic [OUT_WIDTH-1:0] dst_enq_v,
    output logic                 busy,
    output logic [WORDS_W-1:0]   words_done
);

    localparam int unsigned RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned IDX_W = (RATIO >= 2) ? clog2(RATIO) : 1;

    generate
        if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
            $error("fifo_width_down_drain: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORDS_W-1:0]   words_done_q, words_done_d;
    logic                 valid;
    logic                 last;

    assign valid = (state_q == SENDING);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= EMPTY;
            hold_q       <= '0;
            idx_q        <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
        end
    end

    // Strobes are gated by RST so they drop the instant reset is asserted, not at the next edge.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;

        dst_enq__ENA = valid & dst_enq__RDY & ~RST;
        last         = dst_enq__ENA & (idx_q == IDX_W'(RATIO - 1));
        src_deq__ENA = src_deq__RDY & src_first__RDY & (~valid | last) & ~RST;

        if (dst_enq__ENA) begin
            if (last) begin
                state_d      = EMPTY;
                idx_d        = '0;
                words_done_d = words_done_q + 16'd1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // A load in the same cycle as the last beat overrides the return to EMPTY.
        if (src_deq__ENA) begin
            state_d = SENDING;
            hold_d  = src_first;
            idx_d   = '0;
        end
    end

    assign dst_enq_v  = OUT_WIDTH'(beat_select(MAX_W'(hold_q), 32'(idx_q), MSB_FIRST, OUT_WIDTH, RATIO));
    assign busy       = valid;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_fifo_width_down_drain.sv
// Directed bench for fifo_width_down_drain: MSB-first and LSB-first instances share all stimulus.
module tb_fifo_width_down_drain;

    logic        CLK;
    logic        RST;
    logic [15:0] src_first;
    logic        src_first_rdy;
    logic        src_deq_rdy;
    logic        dst_enq_rdy;

    logic        deq_ena,   deq_ena_l;
    logic        enq_ena,   enq_ena_l;
    logic [7:0]  enq_v,     enq_v_l;
    logic        busy,      busy_l;
    logic [15:0] wdone,     wdone_l;

    int checks;
    int failures;

    fifo_width_down_drain #(.IN_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .src_first(src_first), .src_first__RDY(src_first_rdy),
        .src_deq__RDY(src_deq_rdy), .src_deq__ENA(deq_ena),
        .dst_enq__RDY(dst_enq_rdy), .dst_enq__ENA(enq_ena), .dst_enq_v(enq_v),
        .busy(busy), .words_done(wdone)
    );

    fifo_width_down_drain #(.IN_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RST(RST),
        .src_first(src_first), .src_first__RDY(src_first_rdy),
        .src_deq__RDY(src_deq_rdy), .src_deq__ENA(deq_ena_l),
        .dst_enq__RDY(dst_enq_rdy), .dst_enq__ENA(enq_ena_l), .dst_enq_v(enq_v_l),
        .busy(busy_l), .words_done(wdone_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; checks happen 4 units after it.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        src_first = 16'hFFFF; src_first_rdy = 1'b1; src_deq_rdy = 1'b1; dst_enq_rdy = 1'b1;
        cyc(); cyc();
        settle();
        checks++; if (deq_ena !== 1'b0) begin failures++; $display("FAIL reset_deq_ena got=%b exp=0", deq_ena); end
        checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL reset_enq_ena got=%b exp=0", enq_ena); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wdone !== 16'h0000) begin failures++; $display("FAIL reset_words_done got=%h exp=0000", wdone); end
        src_first_rdy = 1'b0; src_deq_rdy = 1'b0;
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    task automatic test_msb_basic();
        src_first = 16'hA1B2; src_first_rdy = 1'b1; src_deq_rdy = 1'b1; dst_enq_rdy = 1'b1;
        settle();
        checks++; if (deq_ena !== 1'b1) begin failures++; $display("FAIL basic_deq got=%b exp=1", deq_ena); end
        checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL basic_enq_c1 got=%b exp=0", enq_ena); end
        cyc();
        src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'hA1) begin failures++; $display("FAIL basic_beat0 ena=%b v=%h exp ena=1 v=a1", enq_ena, enq_v); end
        checks++; if (deq_ena !== 1'b0) begin failures++; $display("FAIL basic_no_deq got=%b exp=0", deq_ena); end
        cyc();
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'hB2) begin failures++; $display("FAIL basic_beat1 ena=%b v=%h exp ena=1 v=b2", enq_ena, enq_v); end
        cyc();
        settle();
        checks++; if (busy !== 1'b0 || enq_ena !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%b ena=%b exp 0 0", busy, enq_ena); end
        checks++; if (wdone !== 16'd1) begin failures++; $display("FAIL basic_words_done got=%0d exp=1", wdone); end
        cyc();
    endtask

    task automatic test_lsb_first();
        src_first = 16'h1234; src_first_rdy = 1'b1;
        settle();
        checks++; if (deq_ena_l !== 1'b1) begin failures++; $display("FAIL lsb_deq got=%b exp=1", deq_ena_l); end
        cyc();
        src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_ena_l !== 1'b1 || enq_v_l !== 8'h34) begin failures++; $display("FAIL lsb_beat0 ena=%b v=%h exp ena=1 v=34", enq_ena_l, enq_v_l); end
        checks++; if (enq_v !== 8'h12) begin failures++; $display("FAIL msb_beat0_of_1234 got=%h exp=12", enq_v); end
        cyc();
        settle();
        checks++; if (enq_ena_l !== 1'b1 || enq_v_l !== 8'h12) begin failures++; $display("FAIL lsb_beat1 ena=%b v=%h exp ena=1 v=12", enq_ena_l, enq_v_l); end
        cyc();
        settle();
        checks++; if (wdone_l !== 16'd2 || busy_l !== 1'b0) begin failures++; $display("FAIL lsb_done words=%0d busy=%b exp 2 0", wdone_l, busy_l); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [7:0]  beats [6];
        words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506;
        beats[0] = 8'h01; beats[1] = 8'h02; beats[2] = 8'h03;
        beats[3] = 8'h04; beats[4] = 8'h05; beats[5] = 8'h06;
        src_first = words[0]; src_first_rdy = 1'b1;
        settle();
        checks++; if (deq_ena !== 1'b1) begin failures++; $display("FAIL b2b_first_deq got=%b exp=1", deq_ena); end
        cyc();
        for (int i = 0; i < 6; i++) begin
            if ((i % 2 == 1) && (i < 5)) begin
                src_first = words[(i + 1) / 2]; src_first_rdy = 1'b1;
            end else begin
                src_first_rdy = 1'b0;
            end
            settle();
            checks++;
            if (enq_ena !== 1'b1 || enq_v !== beats[i]) begin
                failures++; $display("FAIL b2b_beat%0d ena=%b v=%h exp ena=1 v=%h", i, enq_ena, enq_v, beats[i]);
            end
            checks++;
            if (deq_ena !== ((i % 2 == 1) && (i < 5))) begin
                failures++; $display("FAIL b2b_deq%0d got=%b exp=%b", i, deq_ena, ((i % 2 == 1) && (i < 5)));
            end
            cyc();
        end
        settle();
        checks++; if (wdone !== 16'd5 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done words=%0d busy=%b exp 5 0", wdone, busy); end
        cyc();
    endtask

    task automatic test_stall();
        src_first = 16'hCAFE; src_first_rdy = 1'b1; dst_enq_rdy = 1'b1;
        cyc();
        src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'hCA) begin failures++; $display("FAIL stall_beat0 ena=%b v=%h exp ena=1 v=ca", enq_ena, enq_v); end
        cyc();
        dst_enq_rdy = 1'b0; src_first = 16'h1111; src_first_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (enq_ena !== 1'b0 || enq_v !== 8'hFE || deq_ena !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d ena=%b v=%h deq=%b busy=%b exp 0 fe 0 1", i, enq_ena, enq_v, deq_ena, busy);
            end
            cyc();
        end
        dst_enq_rdy = 1'b1; src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'hFE) begin failures++; $display("FAIL stall_resume ena=%b v=%h exp ena=1 v=fe", enq_ena, enq_v); end
        cyc();
        settle();
        checks++; if (wdone !== 16'd6 || busy !== 1'b0) begin failures++; $display("FAIL stall_done words=%0d busy=%b exp 6 0", wdone, busy); end
        cyc();
    endtask

    task automatic test_async_reset();
        src_first = 16'hBEEF; src_first_rdy = 1'b1; dst_enq_rdy = 1'b1;
        cyc();
        src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_v !== 8'hBE) begin failures++; $display("FAIL arst_beat0 got=%h exp=be", enq_v); end
        cyc();
        src_first = 16'h5A6B; src_first_rdy = 1'b1;
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'hEF) begin failures++; $display("FAIL arst_pre ena=%b v=%h exp 1 ef", enq_ena, enq_v); end
        RST = 1'b1;
        #1;
        checks++;
        if (enq_ena !== 1'b0 || deq_ena !== 1'b0 || busy !== 1'b0 || wdone !== 16'd0) begin
            failures++; $display("FAIL arst_mid enq=%b deq=%b busy=%b words=%0d exp 0 0 0 0", enq_ena, deq_ena, busy, wdone);
        end
        cyc();
        RST = 1'b0;
        settle();
        checks++; if (deq_ena !== 1'b1 || enq_ena !== 1'b0) begin failures++; $display("FAIL arst_reload deq=%b enq=%b exp 1 0", deq_ena, enq_ena); end
        cyc();
        src_first_rdy = 1'b0;
        settle();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 8'h5A) begin failures++; $display("FAIL arst_new_beat0 ena=%b v=%h exp 1 5a", enq_ena, enq_v); end
        cyc();
        settle();
        checks++; if (enq_v !== 8'h6B) begin failures++; $display("FAIL arst_new_beat1 got=%h exp=6b", enq_v); end
        cyc();
        settle();
        checks++; if (wdone !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL arst_done words=%0d busy=%b exp 1 0", wdone, busy); end
        cyc();
    endtask

    task automatic test_wrap_and_guard();
        int fires;
        int deqs;
        int budget;
        force dut.words_done_q = 16'hFFFF;
        #1;
        release dut.words_done_q;
        settle();
        checks++; if (wdone !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", wdone); end
        cyc();
        fires = 0; deqs = 0; budget = 0;
        src_first = 16'h7777;
        while (fires < 2 && budget < 200) begin
            dst_enq_rdy   = 1'($urandom_range(0, 1));
            src_deq_rdy   = 1'($urandom_range(0, 1));
            src_first_rdy = (deqs == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            settle();
            checks++;
            if ((enq_ena && !dst_enq_rdy) || (deq_ena && !(src_deq_rdy && src_first_rdy))) begin
                failures++; $display("FAIL wrap_guard enq=%b rdy=%b deq=%b deq_rdy=%b first_rdy=%b", enq_ena, dst_enq_rdy, deq_ena, src_deq_rdy, src_first_rdy);
            end
            if (enq_ena) fires++;
            if (deq_ena) deqs++;
            budget++;
            cyc();
        end
        checks++; if (fires != 2) begin failures++; $display("FAIL wrap_timeout beats=%0d exp=2", fires); end
        dst_enq_rdy = 1'b0; src_first_rdy = 1'b0;
        settle();
        checks++; if (wdone !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL wrap_done words=%h busy=%b exp 0000 0", wdone, busy); end
        cyc();
        for (int i = 0; i < 150; i++) begin
            src_first     = 16'($urandom);
            dst_enq_rdy   = 1'($urandom_range(0, 1));
            src_deq_rdy   = 1'($urandom_range(0, 1));
            src_first_rdy = 1'($urandom_range(0, 1));
            settle();
            checks++;
            if ((enq_ena && !dst_enq_rdy) || (deq_ena && !(src_deq_rdy && src_first_rdy)) ||
                (enq_ena_l && !dst_enq_rdy) || (deq_ena_l && !(src_deq_rdy && src_first_rdy))) begin
                failures++; $display("FAIL rand_guard%0d enq=%b deq=%b rdy=%b/%b/%b", i, enq_ena, deq_ena, dst_enq_rdy, src_deq_rdy, src_first_rdy);
            end
            cyc();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RST = 1'b1;
        src_first = '0; src_first_rdy = 1'b0; src_deq_rdy = 1'b0; dst_enq_rdy = 1'b0;
        #1;
        test_reset();
        test_msb_basic();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_wrap_and_guard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
